// File: rtl/ramb_pkg.sv
// Shared constants and helpers for the parametrised single-port block-RAM family.
package ramb_pkg;

   localparam logic [1:0] WM_WRITE_FIRST = 2'd0;
   localparam logic [1:0] WM_READ_FIRST  = 2'd1;
   localparam logic [1:0] WM_NO_CHANGE   = 2'd2;

   // Widest word and lane count byte_merge can handle; callers zero-extend into these.
   localparam int unsigned MERGE_MAX_W     = 256;
   localparam int unsigned MERGE_MAX_LANES = 256;

   function automatic logic [MERGE_MAX_W-1:0] byte_merge(
      input logic [MERGE_MAX_W-1:0]     old_word,
      input logic [MERGE_MAX_W-1:0]     new_word,
      input logic [MERGE_MAX_LANES-1:0] we,
      input int unsigned                byte_width
   );
      logic [MERGE_MAX_W-1:0] res;
      res = old_word;
      for (int unsigned i = 0; i < MERGE_MAX_W; i++) begin
         if (we[i / byte_width]) begin
            res[i] = new_word[i];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ramb_sp_param_if.sv
// Port-side bus of ramb_sp_param: enable, lane write enables, address, data in/out.
interface ramb_sp_param_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned BYTE_WIDTH = 8
);
   localparam int unsigned NBYTE = DATA_WIDTH / BYTE_WIDTH;

   logic                  EN;
   logic [NBYTE-1:0]      WE;
   logic [ADDR_WIDTH-1:0] ADDR;
   logic [DATA_WIDTH-1:0] DI;
   logic [DATA_WIDTH-1:0] DO;

   modport master (output EN, WE, ADDR, DI, input DO);
   modport slave  (input EN, WE, ADDR, DI, output DO);

endinterface

// File: rtl/ramb_doreg.sv
// Optional DO pipeline stage: synchronous reset to SRVAL, otherwise captures every cycle.
module ramb_doreg #(
   parameter int unsigned       WIDTH = 16,
   parameter logic [WIDTH-1:0]  SRVAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q = SRVAL;

   // Reset ignores any enable: this stage is free-running.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q_q <= SRVAL;
      end else begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/ramb_sp_param.sv
// Parametrised single-port synchronous block RAM with lane write enables and write modes.
// Define RAMB_DOREG_EN to add a second DO register stage (2-cycle read latency).
module ramb_sp_param
   import ramb_pkg::*;
#(
   parameter int unsigned                            DATA_WIDTH = 16,
   parameter int unsigned                            ADDR_WIDTH = 8,
   parameter int unsigned                            BYTE_WIDTH = 8,
   parameter logic [1:0]                             WRITE_MODE = WM_WRITE_FIRST,
   parameter logic [DATA_WIDTH-1:0]                  SRVAL      = '0,
   parameter logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0]  INIT       = '0
) (
   input logic            CLK,
   input logic            RST,
   ramb_sp_param_if.slave bus
);

   localparam int unsigned NBYTE = DATA_WIDTH / BYTE_WIDTH;
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
      $fatal(1, "ramb_sp_param: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end
   if (WRITE_MODE > WM_NO_CHANGE) begin : g_bad_mode
      $fatal(1, "ramb_sp_param: unknown WRITE_MODE");
   end
   if (DATA_WIDTH > MERGE_MAX_W) begin : g_too_wide
      $fatal(1, "ramb_sp_param: DATA_WIDTH exceeds byte_merge capacity");
   end

   // Flat word array so INIT can seed it directly as a power-up value.
   logic [DATA_WIDTH*DEPTH-1:0] mem_q = INIT;
   logic [DATA_WIDTH-1:0]       do_q  = SRVAL;
   logic [DATA_WIDTH-1:0]       do_d;
   logic [DATA_WIDTH-1:0]       rd_word;
   logic [DATA_WIDTH-1:0]       merged;
   logic [NBYTE-1:0]            we;
   logic [31:0]                 base;

   assign we      = bus.WE;
   assign base    = 32'(bus.ADDR) * DATA_WIDTH;
   assign rd_word = mem_q[base +: DATA_WIDTH];
   assign merged  = DATA_WIDTH'(byte_merge(MERGE_MAX_W'(rd_word), MERGE_MAX_W'(bus.DI),
                                           MERGE_MAX_LANES'(we), BYTE_WIDTH));

   always_comb begin
      do_d = do_q;
      if (bus.EN) begin
         if (RST) begin
            do_d = SRVAL;
         end else if (we == '0) begin
            do_d = $isunknown(bus.ADDR) ? 'x : rd_word;
         end else begin
            case (WRITE_MODE)
               WM_WRITE_FIRST: do_d = merged;
               WM_READ_FIRST:  do_d = rd_word;
               default:        do_d = do_q;
            endcase
         end
      end
   end

   // Writes proceed regardless of RST; RST only affects the DO path.
   always_ff @(posedge CLK) begin
      if (bus.EN && (we != '0)) begin
         if ($isunknown(bus.ADDR)) begin
            mem_q <= 'x;
         end else begin
            mem_q[base +: DATA_WIDTH] <= merged;
         end
      end
      do_q <= do_d;
   end

`ifdef RAMB_DOREG_EN
   ramb_doreg #(
      .WIDTH (DATA_WIDTH),
      .SRVAL (SRVAL)
   ) u_doreg (
      .clk_i (CLK),
      .rst_i (RST),
      .d_i   (do_q),
      .q_o   (bus.DO)
   );
`else
   assign bus.DO = do_q;
`endif

endmodule

// File: tb/tb_ramb_sp_param.sv
// Self-checking bench for ramb_sp_param: three 16-bit write-mode variants plus a 32-bit geometry.
module tb_ramb_sp_param;
   import ramb_pkg::*;

   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 256;
   localparam logic [DW*DEPTH-1:0] INIT_A = ((DW*DEPTH)'(16'h1234) << (5*DW)) |
                                            ((DW*DEPTH)'(16'hBEEF) << (3*DW));
   localparam logic [DW*DEPTH-1:0] INIT_B = (DW*DEPTH)'(16'h0F0F) << (7*DW);
   localparam logic [15:0] SR_A = 16'h5A5A;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en;
   logic [1:0]  we;
   logic [7:0]  addr;
   logic [15:0] di;
   logic        en32;
   logic [3:0]  we32;
   logic [9:0]  addr32;
   logic [31:0] di32;

   ramb_sp_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .BYTE_WIDTH(8)) if_a ();
   ramb_sp_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .BYTE_WIDTH(8)) if_b ();
   ramb_sp_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .BYTE_WIDTH(8)) if_c ();
   ramb_sp_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .BYTE_WIDTH(8)) if_d ();

   assign if_a.EN = en;  assign if_a.WE = we;  assign if_a.ADDR = addr;  assign if_a.DI = di;
   assign if_b.EN = en;  assign if_b.WE = we;  assign if_b.ADDR = addr;  assign if_b.DI = di;
   assign if_c.EN = en;  assign if_c.WE = we;  assign if_c.ADDR = addr;  assign if_c.DI = di;
   assign if_d.EN = en32; assign if_d.WE = we32; assign if_d.ADDR = addr32; assign if_d.DI = di32;

   ramb_sp_param #(.WRITE_MODE(WM_WRITE_FIRST), .SRVAL(SR_A), .INIT(INIT_A))
      u_wf (.CLK(clk), .RST(rst), .bus(if_a));
   ramb_sp_param #(.WRITE_MODE(WM_READ_FIRST), .SRVAL(16'h0000), .INIT(INIT_B))
      u_rf (.CLK(clk), .RST(rst), .bus(if_b));
   ramb_sp_param #(.WRITE_MODE(WM_NO_CHANGE), .SRVAL(16'h0000), .INIT(INIT_B))
      u_nc (.CLK(clk), .RST(rst), .bus(if_c));
   ramb_sp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .BYTE_WIDTH(8),
                   .WRITE_MODE(WM_WRITE_FIRST), .SRVAL(32'h0), .INIT('0))
      u_w32 (.CLK(clk), .RST(rst), .bus(if_d));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: word arrays and the spec's DO rules, one call per clock edge.
   logic [15:0] m_mem [3][DEPTH];
   logic [15:0] m_lat [3];
   logic [15:0] m_out [3];
   logic [1:0]  m_mode [3];
   logic [15:0] m_sr [3];

   task automatic model_edge(input logic e, input logic r, input logic [1:0] w,
                             input logic [7:0] a, input logic [15:0] d);
      logic [15:0] old, nw, prev;
      for (int k = 0; k < 3; k++) begin
         old  = m_mem[k][a];
         nw   = old;
         prev = m_lat[k];
         for (int b = 0; b < 2; b++) if (w[b]) nw[b*8 +: 8] = d[b*8 +: 8];
         if (e) begin
            if (r)            m_lat[k] = m_sr[k];
            else if (w == 0)  m_lat[k] = old;
            else if (m_mode[k] == WM_WRITE_FIRST) m_lat[k] = nw;
            else if (m_mode[k] == WM_READ_FIRST)  m_lat[k] = old;
            m_mem[k][a] = nw;
         end
`ifdef RAMB_DOREG_EN
         m_out[k] = r ? m_sr[k] : prev;
`else
         m_out[k] = m_lat[k];
`endif
      end
   endtask

   task automatic step(input logic e, input logic r, input logic [1:0] w,
                       input logic [7:0] a, input logic [15:0] d);
      en = e; rst = r; we = w; addr = a; di = d;
      @(posedge clk);
      model_edge(e, r, w, a, d);
      #1;
   endtask

   task automatic step32(input logic e, input logic [3:0] w, input logic [9:0] a,
                         input logic [31:0] d);
      en32 = e; we32 = w; addr32 = a; di32 = d;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        en, rst;
      logic [1:0]  we;
      logic [7:0]  addr;
      logic [15:0] di;
      logic [15:0] exp_a, exp_b, exp_c;
   } vec_t;
   vec_t tbl [12];

   initial begin
      m_mode = '{WM_WRITE_FIRST, WM_READ_FIRST, WM_NO_CHANGE};
      m_sr   = '{SR_A, 16'h0000, 16'h0000};
      for (int i = 0; i < 3; i++) begin
         m_lat[i] = m_sr[i];
         m_out[i] = m_sr[i];
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         m_mem[0][i] = INIT_A[i*16 +: 16];
         m_mem[1][i] = INIT_B[i*16 +: 16];
         m_mem[2][i] = INIT_B[i*16 +: 16];
      end
      //         en    rst   we     addr   di        wf        rf        nc
      tbl[0]  = '{1'b1, 1'b0, 2'b00, 8'd3, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
      tbl[1]  = '{1'b1, 1'b0, 2'b01, 8'd5, 16'hABCD, 16'h12CD, 16'h0000, 16'h0000};
      tbl[2]  = '{1'b1, 1'b0, 2'b00, 8'd5, 16'h0000, 16'h12CD, 16'h00CD, 16'h00CD};
      tbl[3]  = '{1'b1, 1'b0, 2'b11, 8'd7, 16'hFFFF, 16'hFFFF, 16'h0F0F, 16'h00CD};
      tbl[4]  = '{1'b1, 1'b0, 2'b00, 8'd7, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      tbl[5]  = '{1'b1, 1'b1, 2'b11, 8'd2, 16'h1111, 16'h5A5A, 16'h0000, 16'h0000};
      tbl[6]  = '{1'b1, 1'b0, 2'b00, 8'd2, 16'h0000, 16'h1111, 16'h1111, 16'h1111};
      tbl[7]  = '{1'b0, 1'b1, 2'b11, 8'd2, 16'h2222, 16'h1111, 16'h1111, 16'h1111};
      tbl[8]  = '{1'b1, 1'b0, 2'b00, 8'd2, 16'h0000, 16'h1111, 16'h1111, 16'h1111};
      tbl[9]  = '{1'b1, 1'b0, 2'b10, 8'd3, 16'h7700, 16'h77EF, 16'h0000, 16'h1111};
      tbl[10] = '{1'b1, 1'b1, 2'b00, 8'd3, 16'h0000, 16'h5A5A, 16'h0000, 16'h0000};
      tbl[11] = '{1'b1, 1'b0, 2'b00, 8'd3, 16'h0000, 16'h77EF, 16'h7700, 16'h7700};

      rst = 1'b0; en = 1'b0; we = '0; addr = '0; di = '0;
      en32 = 1'b0; we32 = '0; addr32 = '0; di32 = '0;
      #1;
      check("pwrup_wf", if_a.DO, 32'h5A5A);
      check("pwrup_rf", if_b.DO, 32'h0000);
      check("pwrup_nc", if_c.DO, 32'h0000);
      check("pwrup_w32", if_d.DO, 32'h0);

      // Read latency of the INIT word.
      step(1'b1, 1'b0, 2'b00, 8'd3, 16'h0);
`ifdef RAMB_DOREG_EN
      check("lat_stage1", if_a.DO, 32'h5A5A);
      step(1'b0, 1'b0, 2'b00, 8'd0, 16'h0);
`endif
      check("lat_read", if_a.DO, 32'hBEEF);

      // Each vector is followed by an idle edge so both builds see the latched result.
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].en, tbl[i].rst, tbl[i].we, tbl[i].addr, tbl[i].di);
         step(1'b0, 1'b0, 2'b00, 8'd0, 16'h0);
         check($sformatf("tbl%0d_wf", i), if_a.DO, tbl[i].exp_a);
         check($sformatf("tbl%0d_rf", i), if_b.DO, tbl[i].exp_b);
         check($sformatf("tbl%0d_nc", i), if_c.DO, tbl[i].exp_c);
      end

      // EN=0 with RST=1: latch holds, output stage (if present) resets.
      step(1'b0, 1'b1, 2'b11, 8'd3, 16'h3333);
`ifdef RAMB_DOREG_EN
      check("en0rst_wf", if_a.DO, 32'h5A5A);
      check("en0rst_rf", if_b.DO, 32'h0000);
`else
      check("en0rst_wf", if_a.DO, 32'h77EF);
      check("en0rst_rf", if_b.DO, 32'h7700);
`endif
      step(1'b1, 1'b0, 2'b00, 8'd3, 16'h0);
      step(1'b0, 1'b0, 2'b00, 8'd0, 16'h0);
      check("en0_mem_kept_wf", if_a.DO, 32'h77EF);
      check("en0_mem_kept_nc", if_c.DO, 32'h7700);

      // Random traffic on a small address window against the model.
      for (int n = 0; n < 400; n++) begin
         step(($urandom % 8) != 0, ($urandom % 8) == 0, 2'($urandom % 4),
              8'($urandom % 16), 16'($urandom));
         check($sformatf("rnd%0d_wf", n), if_a.DO, m_out[0]);
         check($sformatf("rnd%0d_rf", n), if_b.DO, m_out[1]);
         check($sformatf("rnd%0d_nc", n), if_c.DO, m_out[2]);
      end

      // 32-bit geometry, top address, alternate lanes.
      en = 1'b0; rst = 1'b0;
      step32(1'b1, 4'b1010, 10'd1023, 32'hDEADBEEF);
      step32(1'b0, 4'b0000, 10'd0, 32'h0);
      check("w32_wf_do", if_d.DO, 32'hDE00BE00);
      step32(1'b1, 4'b0000, 10'd0, 32'h0);
      step32(1'b0, 4'b0000, 10'd0, 32'h0);
      check("w32_addr0", if_d.DO, 32'h0);
      step32(1'b1, 4'b0000, 10'd1023, 32'h0);
      step32(1'b0, 4'b0000, 10'd0, 32'h0);
      check("w32_rd1023", if_d.DO, 32'hDE00BE00);
      step32(1'b1, 4'b0000, 10'd1022, 32'h0);
      step32(1'b0, 4'b0000, 10'd0, 32'h0);
      check("w32_rd1022", if_d.DO, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
